// File: rtl/count_pattern_monitor.sv
// Observer for the reconfigurable counter/shifter LED pattern: classifies each change, locks onto the mode, flags sequence errors and stalls.
// Build option COUNT_PATTERN_MONITOR_SYNC_EN adds a 2-flop synchroniser on count_in (latency 3 instead of 1).
module count_pattern_monitor #(
  parameter int LOCK_N    = 3,
  parameter int TIMEOUT_W = 26,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             decouple,
  input  logic [3:0]       count_in,
  output logic [2:0]       mode,
  output logic             locked,
  output logic             stall,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_STALL  = 2'd3;

  localparam logic [3:0]           LOCK_THR = 4'(LOCK_N);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;

  logic [3:0] sample;

`ifdef COUNT_PATTERN_MONITOR_SYNC_EN
  logic [3:0] sync_a, sync_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= count_in;
      sync_b <= sync_a;
    end
  end

  assign sample = sync_b;
`else
  assign sample = count_in;
`endif

  logic [1:0]           state, state_nxt;
  logic [3:0]           prev;
  logic [3:0]           cand, cand_nxt;
  logic [3:0]           acq, acq_nxt;
  logic [TIMEOUT_W-1:0] tmo, tmo_nxt, tmo_adv;
  logic [2:0]           mode_nxt;
  logic                 locked_nxt, stall_nxt, err_pulse_nxt;
  logic [ERR_W-1:0]     err_count_nxt;

  logic       change;
  logic [3:0] mask, hit, acq_inc, seed_acq, acq_cand, acq_run;

  // Mask bits {ROTR, ROTL, DOWN, UP}; several may be set for one transition.
  assign mask[0] = (sample == prev + 4'd1);
  assign mask[1] = (sample == prev - 4'd1);
  assign mask[2] = (sample == {prev[2:0], prev[3]});
  assign mask[3] = (sample == {prev[0], prev[3:1]});

  assign change   = (sample != prev);
  assign hit      = mask & cand;
  assign acq_inc  = (acq == 4'hF) ? acq : acq + 4'd1;
  assign seed_acq = {3'b000, mask != 4'd0};
  assign acq_cand = (hit != 4'd0) ? hit : mask;
  assign acq_run  = (hit != 4'd0) ? acq_inc : seed_acq;
  assign tmo_adv  = change ? '0 : ((tmo == TMO_MAX) ? tmo : tmo + 1'b1);

  function automatic logic [2:0] encode(input logic [3:0] oh);
    case (oh)
      4'b0001: return 3'd1;
      4'b0010: return 3'd2;
      4'b0100: return 3'd3;
      4'b1000: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  always_comb begin
    state_nxt     = state;
    cand_nxt      = cand;
    acq_nxt       = acq;
    tmo_nxt       = '0;
    mode_nxt      = mode;
    locked_nxt    = locked;
    stall_nxt     = stall;
    err_pulse_nxt = 1'b0;
    err_count_nxt = err_count;

    if (decouple) begin
      state_nxt  = ST_IDLE;
      cand_nxt   = 4'hF;
      acq_nxt    = 4'd0;
      mode_nxt   = 3'd0;
      locked_nxt = 1'b0;
      stall_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_ACQ;
          cand_nxt  = 4'hF;
          acq_nxt   = 4'd0;
        end
        ST_ACQ: begin
          tmo_nxt = tmo_adv;
          if (change) begin
            cand_nxt = acq_cand;
            acq_nxt  = acq_run;
            if (acq_run >= LOCK_THR && is_onehot(acq_cand)) begin
              state_nxt  = ST_LOCKED;
              locked_nxt = 1'b1;
              mode_nxt   = encode(acq_cand);
            end
          end else if (tmo_adv == TMO_MAX) begin
            state_nxt  = ST_STALL;
            stall_nxt  = 1'b1;
            cand_nxt   = 4'hF;
            acq_nxt    = 4'd0;
          end
        end
        ST_LOCKED: begin
          tmo_nxt = tmo_adv;
          // cand holds exactly the locked mode bit here
          if (change) begin
            if (hit == 4'd0) begin
              state_nxt     = ST_ACQ;
              err_pulse_nxt = 1'b1;
              err_count_nxt = (err_count == '1) ? err_count : err_count + 1'b1;
              locked_nxt    = 1'b0;
              mode_nxt      = 3'd0;
              cand_nxt      = mask;
              acq_nxt       = seed_acq;
            end
          end else if (tmo_adv == TMO_MAX) begin
            state_nxt  = ST_STALL;
            stall_nxt  = 1'b1;
            locked_nxt = 1'b0;
            mode_nxt   = 3'd0;
            cand_nxt   = 4'hF;
            acq_nxt    = 4'd0;
          end
        end
        default: begin
          tmo_nxt = tmo_adv;
          if (change) begin
            state_nxt = ST_ACQ;
            stall_nxt = 1'b0;
            cand_nxt  = mask;
            acq_nxt   = seed_acq;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      prev      <= '0;
      cand      <= 4'hF;
      acq       <= '0;
      tmo       <= '0;
      mode      <= '0;
      locked    <= 1'b0;
      stall     <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      prev      <= sample;
      cand      <= cand_nxt;
      acq       <= acq_nxt;
      tmo       <= tmo_nxt;
      mode      <= mode_nxt;
      locked    <= locked_nxt;
      stall     <= stall_nxt;
      err_pulse <= err_pulse_nxt;
      err_count <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_count_pattern_monitor.sv
// Bench for count_pattern_monitor: directed scenarios plus random walks, every cycle compared against a rule-level model.
module tb_count_pattern_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       decouple = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic [2:0] mode;
  logic       locked, stall, err_pulse;
  logic [7:0] err_count;

  count_pattern_monitor #(.LOCK_N(3), .TIMEOUT_W(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .decouple(decouple), .count_in(count_in),
    .mode(mode), .locked(locked), .stall(stall), .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

`ifdef COUNT_PATTERN_MONITOR_SYNC_EN
  localparam int XL = 2;
`else
  localparam int XL = 0;
`endif

  int total = 0;
  int fails = 0;

  // reference model: phase 0 idle, 1 acquiring, 2 locked, 3 stalled
  int         m_ph = 0;
  logic [3:0] m_prev = 4'd0;
  bit         m_ok[4] = '{1, 1, 1, 1};
  int         m_run = 0;
  int         m_quiet = 0;
  int         m_mode = 0;
  bit         m_lock = 0, m_stall = 0, m_err = 0;
  int         m_ec = 0;
  logic [3:0] s1 = 4'd0, s2 = 4'd0;

  function automatic logic [3:0] next_of(input int k, input logic [3:0] p);
    int v = int'(p);
    case (k)
      0:       return 4'((v + 1) % 16);
      1:       return 4'((v + 15) % 16);
      2:       return 4'((v * 2) % 16 + v / 8);
      default: return 4'(v / 2 + (v % 2) * 8);
    endcase
  endfunction

  task automatic m_to_stall();
    m_ph = 3; m_stall = 1; m_lock = 0; m_mode = 0; m_run = 0;
    for (int k = 0; k < 4; k++) m_ok[k] = 1;
  endtask

  task automatic model(input logic r, input logic d, input logic [3:0] ci);
    logic [3:0] x;
    bit fits[4];
    bit chg, any;
    int nf, nok, sel;
    if (r) begin
      s1 = 0; s2 = 0; m_ph = 0; m_prev = 0; m_run = 0; m_quiet = 0;
      m_mode = 0; m_lock = 0; m_stall = 0; m_err = 0; m_ec = 0;
      for (int k = 0; k < 4; k++) m_ok[k] = 1;
      return;
    end
`ifdef COUNT_PATTERN_MONITOR_SYNC_EN
    x = s2; s2 = s1; s1 = ci;
`else
    x = ci;
`endif
    m_err = 0;
    if (d) begin
      m_ph = 0; m_lock = 0; m_mode = 0; m_stall = 0; m_quiet = 0; m_run = 0;
      for (int k = 0; k < 4; k++) m_ok[k] = 1;
      m_prev = x;
      return;
    end
    chg = (x != m_prev);
    nf = 0; any = 0;
    for (int k = 0; k < 4; k++) begin
      fits[k] = (next_of(k, m_prev) == x);
      if (fits[k]) nf++;
      if (fits[k] && m_ok[k]) any = 1;
    end
    if (m_ph != 0) m_quiet = chg ? 0 : ((m_quiet < 15) ? m_quiet + 1 : 15);
    case (m_ph)
      0: begin
        m_ph = 1; m_quiet = 0; m_run = 0;
        for (int k = 0; k < 4; k++) m_ok[k] = 1;
      end
      1: begin
        if (chg) begin
          if (any) begin
            for (int k = 0; k < 4; k++) m_ok[k] = m_ok[k] && fits[k];
            m_run = (m_run < 15) ? m_run + 1 : 15;
          end else begin
            for (int k = 0; k < 4; k++) m_ok[k] = fits[k];
            m_run = (nf > 0) ? 1 : 0;
          end
          nok = 0; sel = 0;
          for (int k = 0; k < 4; k++) if (m_ok[k]) begin nok++; sel = k; end
          if (m_run >= 3 && nok == 1) begin
            m_ph = 2; m_lock = 1; m_mode = sel + 1;
          end
        end else if (m_quiet == 15) m_to_stall();
      end
      2: begin
        if (chg) begin
          if (!fits[m_mode - 1]) begin
            m_err = 1; m_ec = (m_ec < 255) ? m_ec + 1 : 255;
            m_ph = 1; m_lock = 0; m_mode = 0;
            for (int k = 0; k < 4; k++) m_ok[k] = fits[k];
            m_run = (nf > 0) ? 1 : 0;
          end
        end else if (m_quiet == 15) m_to_stall();
      end
      default: begin
        if (chg) begin
          m_ph = 1; m_stall = 0;
          for (int k = 0; k < 4; k++) m_ok[k] = fits[k];
          m_run = (nf > 0) ? 1 : 0;
        end
      end
    endcase
    m_prev = x;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] val, input logic dec);
    count_in = val;
    decouple = dec;
    @(posedge clk);
    model(rst, dec, val);
    #1;
    chk("mode", 32'(mode), 32'(m_mode));
    chk("locked", 32'(locked), 32'(m_lock));
    chk("stall", 32'(stall), 32'(m_stall));
    chk("err_pulse", 32'(err_pulse), 32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_ec));
  endtask

  initial begin
    int lock_at, stall_at, ep, e0;
    bit saw_rotl;
    logic [3:0] v;

    rst = 1;
    repeat (2) step(4'h0, 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_err_count", 32'(err_count), 0);
    rst = 0;

    // down sequence
    repeat (4) step(4'hF, 1);
    step(4'hF, 0);
    repeat (5) step(4'hF, 0);
    repeat (5) step(4'hE, 0);
    repeat (5) step(4'hD, 0);
    lock_at = -1;
    for (int i = 0; i < 5; i++) begin
      step(4'hC, 0);
      if (locked === 1'b1 && lock_at < 0) lock_at = i;
    end
    chk("down_lock_latency", 32'(lock_at), 32'(XL));
    chk("down_mode", 32'(mode), 2);
    chk("down_err_count", 32'(err_count), 0);

    // locked DOWN, inconsistent step 1100 -> 0110
    ep = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'h6, 0);
      ep += int'(err_pulse);
    end
    chk("err_pulse_width", 32'(ep), 1);
    chk("err_count_one", 32'(err_count), 1);
    chk("err_unlocked", 32'(locked), 0);
    chk("err_mode", 32'(mode), 0);

    // relock then hold for stall
    repeat (4) step(4'h5, 0);
    repeat (4) step(4'h4, 0);
    lock_at = -1; stall_at = -1;
    for (int i = 0; i < 25; i++) begin
      step(4'h3, 0);
      if (locked === 1'b1 && lock_at < 0) lock_at = i;
      if (stall === 1'b1 && stall_at < 0) stall_at = i;
    end
    chk("stall_delay", 32'(stall_at - lock_at), 15);
    chk("stall_set", 32'(stall), 1);
    chk("stall_unlocked", 32'(locked), 0);
    for (int i = 0; i <= XL; i++) step(4'h2, 0);
    chk("stall_clear", 32'(stall), 0);

    // relock, then decouple with random input
    repeat (4) step(4'h1, 0);
    repeat (4) step(4'h0, 0);
    chk("pre_dec_locked", 32'(locked), 1);
    e0 = int'(err_count);
    ep = 0;
    for (int i = 0; i < 20; i++) begin
      v = 4'($urandom);
      step(v, 1);
      ep += int'(err_pulse);
    end
    chk("dec_locked", 32'(locked), 0);
    chk("dec_no_err", 32'(ep), 0);
    chk("dec_err_held", 32'(err_count), 32'(e0));
    repeat (3) step(4'h8, 1);
    repeat (4) step(4'h8, 0);
    repeat (4) step(4'h7, 0);
    repeat (4) step(4'h6, 0);
    repeat (4) step(4'h5, 0);
    chk("relock_locked", 32'(locked), 1);
    chk("relock_mode", 32'(mode), 2);

    // up sequence from a fresh reset; 0001->0010 is UP|ROTL
    rst = 1;
    repeat (2) step(4'h0, 0);
    rst = 0;
    repeat (4) step(4'h0, 1);
    repeat (6) step(4'h0, 0);
    saw_rotl = 0;
    for (int s = 1; s <= 3; s++) begin
      v = 4'(s);
      for (int i = 0; i < 5; i++) begin
        step(v, 0);
        if (mode === 3'd3) saw_rotl = 1;
      end
    end
    chk("up_never_rotl", 32'(saw_rotl), 0);
    chk("up_locked", 32'(locked), 1);
    chk("up_mode", 32'(mode), 1);

    // random walks with corruption, long holds and decouple bursts
    v = 4'h3;
    for (int n = 0; n < 60; n++) begin
      int k, len, hold;
      k = int'($urandom_range(0, 3));
      len = int'($urandom_range(2, 8));
      hold = int'($urandom_range(1, 6));
      if ($urandom_range(0, 9) == 0) hold = 18;
      for (int j = 0; j < len; j++) begin
        v = next_of(k, v);
        repeat (hold) step(v, 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        v = 4'($urandom);
        step(v, 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        repeat (3) begin
          v = 4'($urandom);
          step(v, 1);
        end
      end
    end

    // mid-lock reset
    repeat (4) step(4'h9, 1);
    repeat (4) step(4'h9, 0);
    repeat (4) step(4'h8, 0);
    repeat (4) step(4'h7, 0);
    repeat (4) step(4'h6, 0);
    chk("midrst_pre_locked", 32'(locked), 1);
    rst = 1;
    step(4'h5, 0);
    chk("midrst_mode", 32'(mode), 0);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_err_pulse", 32'(err_pulse), 0);
    chk("midrst_err_count", 32'(err_count), 0);
    rst = 0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
